// File: rtl/cam_frame_ctrl_if.sv
// Frame-sequencer bus: camera timing, host control and frame status.
// master drives camera/host inputs; slave is the sequencer side.
interface cam_frame_ctrl_if #(
  parameter int ADDR_W = 17
);
  logic              Vsync;
  logic              Href;
  logic              regWrite;
  logic              start;
  logic              continuous;
  logic              abort;
  logic              cap_en;
  logic              addr_clr;
  logic              busy;
  logic              frame_done;
  logic              frame_err;
  logic [1:0]        err_code;
  logic [7:0]        frame_cnt;
  logic [7:0]        line_cnt;
  logic [ADDR_W-1:0] pix_total;

  modport master (
    output Vsync, Href, regWrite,
    output start, continuous, abort,
    input  cap_en, addr_clr, busy,
    input  frame_done, frame_err, err_code,
    input  frame_cnt, line_cnt, pix_total
  );

  modport slave (
    input  Vsync, Href, regWrite,
    input  start, continuous, abort,
    output cap_en, addr_clr, busy,
    output frame_done, frame_err, err_code,
    output frame_cnt, line_cnt, pix_total
  );
endinterface

// File: rtl/cam_frame_ctrl.sv
// OV7670 frame sequencer: arms capture on a clean Vsync boundary,
// checks line/frame geometry and guards the frame buffer.
module cam_frame_ctrl #(
  parameter int H_PIXELS = 160,
  parameter int V_LINES  = 120,
  parameter int ADDR_W   = 17
) (
  input  logic Pclk,
  input  logic Rst_n,
  cam_frame_ctrl_if.slave bus
);

  localparam logic [ADDR_W-1:0] PIX_MAX  =
    ADDR_W'(H_PIXELS * V_LINES);
  localparam logic [ADDR_W-1:0] LINE_PIX =
    ADDR_W'(H_PIXELS);
  localparam logic [7:0] LINES = 8'(V_LINES);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_BLANK,
    WAIT_START,
    ACTIVE,
    DONE
  } state_e;

  state_e            state_q, state_d;
  logic              vs_q, hr_q;
  logic              cap_q, cap_d;
  logic              aclr_q, aclr_d;
  logic              done_q, done_d;
  logic              ferr_q, ferr_d;
  logic [1:0]        err_q, err_d;
  logic [7:0]        fcnt_q, fcnt_d;
  logic [7:0]        line_q, line_d;
  logic [ADDR_W-1:0] pix_q, pix_d;
  logic [ADDR_W-1:0] lpix_q, lpix_d;

  logic vs_fall, vs_rise, href_fall;

  assign vs_fall   = vs_q & ~bus.Vsync;
  assign vs_rise   = ~vs_q & bus.Vsync;
  assign href_fall = hr_q & ~bus.Href;

  always_ff @(posedge Pclk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= IDLE;
      vs_q    <= 1'b1;
      hr_q    <= 1'b0;
      cap_q   <= 1'b0;
      aclr_q  <= 1'b0;
      done_q  <= 1'b0;
      ferr_q  <= 1'b0;
      err_q   <= '0;
      fcnt_q  <= '0;
      line_q  <= '0;
      pix_q   <= '0;
      lpix_q  <= '0;
    end else begin
      state_q <= state_d;
      vs_q    <= bus.Vsync;
      hr_q    <= bus.Href;
      cap_q   <= cap_d;
      aclr_q  <= aclr_d;
      done_q  <= done_d;
      ferr_q  <= ferr_d;
      err_q   <= err_d;
      fcnt_q  <= fcnt_d;
      line_q  <= line_d;
      pix_q   <= pix_d;
      lpix_q  <= lpix_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cap_d   = cap_q;
    aclr_d  = 1'b0;
    done_d  = 1'b0;
    ferr_d  = 1'b0;
    err_d   = err_q;
    fcnt_d  = fcnt_q;
    line_d  = line_q;
    pix_d   = pix_q;
    lpix_d  = lpix_q;
    if (bus.abort) begin
      state_d = IDLE;
      cap_d   = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.start) begin
            state_d = WAIT_BLANK;
            aclr_d  = 1'b1;
          end
        end
        WAIT_BLANK: begin
          if (bus.Vsync) state_d = WAIT_START;
        end
        WAIT_START: begin
          if (vs_fall) begin
            state_d = ACTIVE;
            line_d  = '0;
            pix_d   = '0;
            lpix_d  = '0;
            err_d   = '0;
            cap_d   = 1'b1;
          end
        end
        ACTIVE: begin
          if (bus.regWrite) lpix_d = lpix_q + 1'b1;
          // line check runs before the frame-level events
          if (href_fall) begin
            if (line_q != 8'hFF) line_d = line_q + 8'd1;
            if (lpix_q != LINE_PIX && err_q != 2'd3)
              err_d = 2'd1;
            lpix_d = '0;
          end
          if (bus.regWrite) begin
            if (pix_q == PIX_MAX) begin
              err_d = 2'd3;
            end else if (cap_q) begin
              pix_d = pix_q + 1'b1;
              if (pix_q == PIX_MAX - 1'b1) cap_d = 1'b0;
            end
          end
          if (vs_rise) begin
            state_d = DONE;
            cap_d   = 1'b0;
          end
        end
        DONE: begin
          if (line_q != LINES && err_q == 2'd0)
            err_d = 2'd2;
          done_d = 1'b1;
          ferr_d = (err_d != 2'd0);
          fcnt_d = fcnt_q + 8'd1;
          if (bus.continuous) begin
            state_d = WAIT_START;
            aclr_d  = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign bus.cap_en     = cap_q;
  assign bus.addr_clr   = aclr_q;
  assign bus.busy       = (state_q != IDLE);
  assign bus.frame_done = done_q;
  assign bus.frame_err  = ferr_q;
  assign bus.err_code   = err_q;
  assign bus.frame_cnt  = fcnt_q;
  assign bus.line_cnt   = line_q;
  assign bus.pix_total  = pix_q;

endmodule

// File: tb/tb_cam_frame_ctrl.sv
// Bench for cam_frame_ctrl: directed and randomized frames
// checked against a per-frame geometry model.
module tb_cam_frame_ctrl;
  localparam int H    = 4;
  localparam int V    = 3;
  localparam int AW   = 17;
  localparam int MAXP = H * V;

  logic Pclk  = 1'b0;
  logic Rst_n = 1'b1;

  cam_frame_ctrl_if #(.ADDR_W(AW)) bus ();

  cam_frame_ctrl #(
    .H_PIXELS(H),
    .V_LINES (V),
    .ADDR_W  (AW)
  ) dut (
    .Pclk (Pclk),
    .Rst_n(Rst_n),
    .bus  (bus)
  );

  always #5 Pclk = ~Pclk;

  int npass   = 0;
  int nfail   = 0;
  int ntot    = 0;
  int cap_bad = 0;
  int written = 0;
  int fcnt    = 0;
  int nl      = 0;
  int len [8];
  int n_aclr  = 0;
  int n_idle  = 0;
  int n_done  = 0;
  bit exp_cap = 1'b0;
  int e_err, e_pix, e_line;

  always @(negedge Pclk) begin
    if (bus.addr_clr === 1'b1) n_aclr++;
    if (bus.busy !== 1'b1) n_idle++;
    if (bus.frame_done === 1'b1) n_done++;
  end

  task automatic chk(string tag, logic [31:0] obs,
                     logic [31:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Pclk);
    #1;
    if (bus.cap_en !== exp_cap) cap_bad++;
  endtask

  task automatic model();
    int s = 0;
    bit bad = 1'b0;
    for (int i = 0; i < nl; i++) begin
      s += len[i];
      if (len[i] != H) bad = 1'b1;
    end
    e_pix  = (s > MAXP) ? MAXP : s;
    e_line = nl;
    if (s > MAXP)   e_err = 3;
    else if (bad)   e_err = 1;
    else if (nl != V) e_err = 2;
    else            e_err = 0;
  endtask

  task automatic blank(int n);
    bus.Vsync = 1'b1;
    bus.Href  = 1'b0;
    repeat (n) tick();
  endtask

  task automatic vfall(bit armed);
    bus.Vsync = 1'b0;
    exp_cap   = armed;
    written   = 0;
    tick();
    tick();
  endtask

  task automatic lines();
    for (int l = 0; l < nl; l++) begin
      bus.Href = 1'b1;
      tick();
      for (int p = 0; p < len[l]; p++) begin
        repeat ($urandom_range(0, 1)) tick();
        bus.regWrite = 1'b1;
        if (exp_cap) begin
          written++;
          if (written == MAXP) exp_cap = 1'b0;
        end
        tick();
        bus.regWrite = 1'b0;
      end
      bus.Href = 1'b0;
      tick();
      tick();
    end
  endtask

  task automatic vrise();
    bus.Vsync = 1'b1;
    exp_cap   = 1'b0;
    tick();
  endtask

  task automatic set3(int a, int b, int c);
    nl = 3;
    len[0] = a;
    len[1] = b;
    len[2] = c;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic check_done(string tag, bit exp_busy);
    model();
    chk({tag, "_fd_early"}, 32'(bus.frame_done), 0);
    tick();
    fcnt = (fcnt + 1) % 256;
    chk({tag, "_fd"}, 32'(bus.frame_done), 1);
    chk({tag, "_err"}, 32'(bus.err_code), 32'(e_err));
    chk({tag, "_ferr"}, 32'(bus.frame_err),
        32'(e_err != 0));
    chk({tag, "_fcnt"}, 32'(bus.frame_cnt), 32'(fcnt));
    chk({tag, "_pix"}, 32'(bus.pix_total), 32'(e_pix));
    chk({tag, "_line"}, 32'(bus.line_cnt), 32'(e_line));
    chk({tag, "_busy"}, 32'(bus.busy), 32'(exp_busy));
    tick();
    chk({tag, "_fd_pulse"}, 32'(bus.frame_done), 0);
    chk({tag, "_capwin"}, 32'(cap_bad), 0);
    cap_bad = 0;
  endtask

  task automatic single(string tag);
    pulse_start();
    blank(2);
    vfall(1'b1);
    lines();
    vrise();
    check_done(tag, 1'b0);
  endtask

  initial begin
    int a0, i0, d0;
    bus.Vsync      = 1'b1;
    bus.Href       = 1'b0;
    bus.regWrite   = 1'b0;
    bus.start      = 1'b0;
    bus.continuous = 1'b0;
    bus.abort      = 1'b0;
    #2 Rst_n = 1'b0;
    #1;
    chk("rst_cap", 32'(bus.cap_en), 0);
    chk("rst_aclr", 32'(bus.addr_clr), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_fd", 32'(bus.frame_done), 0);
    chk("rst_err", 32'(bus.err_code), 0);
    chk("rst_fcnt", 32'(bus.frame_cnt), 0);
    chk("rst_pix", 32'(bus.pix_total), 0);
    tick();
    tick();
    Rst_n = 1'b1;
    tick();

    // clean single-shot frame with start latency
    a0 = n_aclr;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("t1_aclr", 32'(bus.addr_clr), 1);
    chk("t1_busy", 32'(bus.busy), 1);
    tick();
    chk("t1_aclr_pulse", 32'(bus.addr_clr), 0);
    blank(2);
    set3(4, 4, 4);
    vfall(1'b1);
    lines();
    vrise();
    check_done("t1", 1'b0);
    chk("t1_aclr_cnt", 32'(n_aclr - a0), 1);

    // start mid-frame: partial frame never enables capture
    d0 = n_done;
    bus.Vsync = 1'b0;
    tick();
    nl = 1;
    len[0] = 4;
    lines();
    pulse_start();
    lines();
    vrise();
    repeat (3) tick();
    chk("t2_nodone", 32'(n_done - d0), 0);
    chk("t2_capwin", 32'(cap_bad), 0);
    chk("t2_busy", 32'(bus.busy), 1);
    cap_bad = 0;
    blank(1);
    set3(4, 4, 4);
    vfall(1'b1);
    lines();
    vrise();
    check_done("t2", 1'b0);

    // line-length error, then a clean frame clears it
    set3(4, 5, 3);
    single("t3_len");
    set3(4, 4, 4);
    single("t3_clean");

    // overflow: 16 strobes into a 12-pixel buffer
    nl = 4;
    for (int i = 0; i < 4; i++) len[i] = 4;
    single("t4_ovf");

    // continuous mode, three frames
    bus.continuous = 1'b1;
    a0 = n_aclr;
    pulse_start();
    i0 = n_idle;
    for (int f = 0; f < 3; f++) begin
      blank(2);
      set3(4, 4, 4);
      vfall(1'b1);
      lines();
      vrise();
      if (f == 2) begin
        chk("t5_busy_win", 32'(n_idle - i0), 0);
        bus.continuous = 1'b0;
      end
      check_done($sformatf("t5_f%0d", f), f != 2);
    end
    chk("t5_aclr_cnt", 32'(n_aclr - a0), 3);

    // randomized single-shot frames against the model
    for (int r = 0; r < 8; r++) begin
      nl = $urandom_range(2, 4);
      for (int i = 0; i < nl; i++)
        len[i] = ($urandom_range(0, 1) == 1) ? H
                 : $urandom_range(H - 1, H + 1);
      single($sformatf("rnd%0d", r));
    end

    // abort beats start, in ACTIVE and in IDLE
    d0 = n_done;
    pulse_start();
    blank(2);
    nl = 1;
    len[0] = 4;
    vfall(1'b1);
    lines();
    bus.abort = 1'b1;
    bus.start = 1'b1;
    exp_cap   = 1'b0;
    tick();
    bus.abort = 1'b0;
    bus.start = 1'b0;
    chk("t6_busy", 32'(bus.busy), 0);
    chk("t6_cap", 32'(bus.cap_en), 0);
    chk("t6_aclr", 32'(bus.addr_clr), 0);
    lines();
    vrise();
    repeat (3) tick();
    chk("t6_nodone", 32'(n_done - d0), 0);
    chk("t6_fcnt", 32'(bus.frame_cnt), 32'(fcnt));
    chk("t6_capwin", 32'(cap_bad), 0);
    cap_bad = 0;
    bus.abort = 1'b1;
    bus.start = 1'b1;
    tick();
    bus.abort = 1'b0;
    bus.start = 1'b0;
    chk("t6_idle_aclr", 32'(bus.addr_clr), 0);
    chk("t6_idle_busy", 32'(bus.busy), 0);

    // asynchronous reset in the middle of a frame
    pulse_start();
    blank(2);
    vfall(1'b1);
    bus.Href     = 1'b1;
    bus.regWrite = 1'b1;
    tick();
    tick();
    chk("t7_cap_pre", 32'(bus.cap_en), 1);
    #2 Rst_n = 1'b0;
    #1;
    chk("t7_cap", 32'(bus.cap_en), 0);
    chk("t7_busy", 32'(bus.busy), 0);
    chk("t7_pix", 32'(bus.pix_total), 0);
    chk("t7_fcnt", 32'(bus.frame_cnt), 0);
    chk("t7_err", 32'(bus.err_code), 0);
    chk("t7_line", 32'(bus.line_cnt), 0);
    bus.regWrite = 1'b0;
    bus.Href     = 1'b0;
    bus.Vsync    = 1'b1;
    exp_cap      = 1'b0;
    tick();
    Rst_n = 1'b1;
    tick();

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
